// File: rtl/mem_bus_responder.sv
// Memory-bus responder: RAM, LED, switch and cycle-counter registers behind a req/ready handshake.
// Define WAIT_STATES_EN to insert WAIT_CYCLES wait states per access.
module mem_bus_responder #(
  parameter int DATA_W      = 32,
  parameter int RAM_WORDS   = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  input  logic [7:0]        sw_in,
  output logic [7:0]        led_out
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [DATA_W-1:0] LED_ADDR = DATA_W'('h7F00);
  localparam logic [DATA_W-1:0] SW_ADDR  = DATA_W'('h7F04);
  localparam logic [DATA_W-1:0] CNT_ADDR = DATA_W'('h7F08);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
    $error("mem_bus_responder: WAIT_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef WAIT_STATES_EN
    WAIT = 2'd1,
`endif
    RESP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              accept, enter_resp, commit;
  logic [DATA_W-1:0] addr_q, wdata_q, cyc_q, rdata_q, cycle_cnt;
  logic              we_q, err_q;
  logic [7:0]        led_q, sw_meta, sw_sync;
  logic [DATA_W-1:0] ram [RAM_WORDS];

  logic [DATA_W-1:0] acc_addr, acc_cyc, rd_val;
  logic              acc_we, misaligned, ram_hit, led_hit, sw_hit, cnt_hit, acc_err;

`ifdef WAIT_STATES_EN
  logic [3:0] wait_cnt;
`endif

  // In IDLE the live inputs are decoded (needed when RESP follows acceptance
  // directly); afterwards only the latched request is used.
  always_comb begin
    acc_addr   = (state == IDLE) ? addr : addr_q;
    acc_we     = (state == IDLE) ? we : we_q;
    acc_cyc    = (state == IDLE) ? cycle_cnt : cyc_q;
    misaligned = |acc_addr[1:0];
    ram_hit    = (acc_addr >> (AW + 2)) == '0;
    led_hit    = acc_addr == LED_ADDR;
    sw_hit     = acc_addr == SW_ADDR;
    cnt_hit    = acc_addr == CNT_ADDR;
    acc_err    = misaligned | ~(ram_hit | led_hit | sw_hit | cnt_hit);
    rd_val     = '0;
    if (!acc_err && !acc_we) begin
      if (ram_hit)      rd_val = ram[acc_addr[AW+1:2]];
      else if (led_hit) rd_val = {{(DATA_W-8){1'b0}}, led_q};
      else if (sw_hit)  rd_val = {{(DATA_W-8){1'b0}}, sw_sync};
      else if (cnt_hit) rd_val = acc_cyc;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
`ifdef WAIT_STATES_EN
          state_nxt = WAIT;
`else
          state_nxt = RESP;
`endif
        end
      end
`ifdef WAIT_STATES_EN
      WAIT:    if (wait_cnt == 4'd1) state_nxt = RESP;
`endif
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    enter_resp = (state_nxt == RESP) && (state != RESP);
    commit     = (state == RESP) && we_q && !err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      cyc_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      led_q     <= '0;
      cycle_cnt <= '0;
      sw_meta   <= '0;
      sw_sync   <= '0;
    end else begin
      state   <= state_nxt;
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        we_q    <= we;
        cyc_q   <= cycle_cnt;
      end
      if (enter_resp) begin
        rdata_q <= rd_val;
        err_q   <= acc_err;
      end
      if (commit && led_hit) led_q <= wdata_q[7:0];
      // A counter clear takes priority over the free-running increment.
      if (commit && cnt_hit) cycle_cnt <= '0;
      else                   cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

`ifdef WAIT_STATES_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              wait_cnt <= '0;
    else if (accept)         wait_cnt <= 4'(WAIT_CYCLES);
    else if (state == WAIT)  wait_cnt <= wait_cnt - 4'd1;
  end
`endif

  // RAM contents survive reset; a write only lands on the RESP edge.
  always_ff @(posedge clk) begin
    if (commit && ram_hit) ram[acc_addr[AW+1:2]] <= wdata_q;
  end

  assign ready   = (state == RESP);
  assign err     = ready & err_q;
  assign rdata   = ready ? rdata_q : '0;
  assign led_out = led_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized scoreboard bench for mem_bus_responder with a behavioural memory-map model.
// Builds with or without WAIT_STATES_EN.
module tb_mem_bus_responder;

  localparam int DATA_W      = 32;
  localparam int RAM_WORDS   = 64;
  localparam int WAIT_CYCLES = 2;
`ifdef WAIT_STATES_EN
  localparam int LAT = WAIT_CYCLES + 1;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready, err;
  logic [7:0]  sw_in = '0;
  logic [7:0]  led_out;

  mem_bus_responder #(.DATA_W(DATA_W), .RAM_WORDS(RAM_WORDS), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err), .sw_in(sw_in), .led_out(led_out)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the DUT cycle counter should track this minus the last clear.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    logic [31:0] rd;
    bit          e;
    bit          checkData;
    logic [7:0]  led;
    int          expCycle;
    int          id;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  int          txnId = 0;
  exp_t        sbq[$];
  logic [31:0] ramModel[RAM_WORDS];
  logic [7:0]  ledModel = '0;
  logic [7:0]  swModel = '0;
  int          clearBase = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory-map rules applied to a request accepted in the cycle numbered n.
  function automatic exp_t modelAccess(input bit w, input logic [31:0] a, input logic [31:0] d, input int n);
    exp_t x;
    int   idx;
    x.rd = '0; x.e = 1'b0; x.checkData = !w; x.expCycle = n + LAT; x.id = txnId;
    idx = int'(a >> 2);
    if (a[1:0] != 2'b00) x.e = 1'b1;
    else if (a < 32'(4 * RAM_WORDS)) begin
      if (w) ramModel[idx] = d; else x.rd = ramModel[idx];
    end else if (a == 32'h7F00) begin
      if (w) ledModel = d[7:0]; else x.rd = {24'h0, ledModel};
    end else if (a == 32'h7F04) begin
      if (!w) x.rd = {24'h0, swModel};
    end else if (a == 32'h7F08) begin
      if (w) clearBase = n + LAT + 1; else x.rd = 32'(n - clearBase);
    end else x.e = 1'b1;
    x.led = ledModel;
    return x;
  endfunction

  // Issue one request; busy cycles keep req high with junk fields that must be ignored.
  task automatic applyStimulus(input bit w, input logic [31:0] a, input logic [31:0] d,
                               input int gap, input bit releaseReset = 1'b0);
    req = 1'b1; we = w; addr = a; wdata = d;
    sbq.push_back(modelAccess(w, a, d, cyc));
    txnId++;
    if (releaseReset) begin
      #2 rst_n = 1'b1;
    end
    @(posedge clk); #1;
    for (int i = 0; i < LAT; i++) begin
      req = 1'b1; we = 1'($urandom); addr = $urandom; wdata = $urandom;
      @(posedge clk); #1;
    end
    req = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic setSwitches(input logic [7:0] v);
    sw_in = v;
    repeat (3) @(posedge clk);
    #1 swModel = v;
  endtask

  function automatic logic [31:0] randomAddr();
    logic [31:0] a;
    a = 32'($urandom_range(0, RAM_WORDS - 1)) << 2;
    case ($urandom_range(0, 6))
      0, 1:    ;
      2:       a = a + 32'($urandom_range(1, 3));
      3:       a = 32'h7F00;
      4:       a = 32'h7F04;
      5:       a = 32'h7F08;
      default: case ($urandom_range(0, 4))
                 0:       a = 32'(4 * RAM_WORDS);
                 1:       a = 32'h9000;
                 2:       a = 32'h7F0C;
                 3:       a = 32'h7F02;
                 default: a = {1'b1, 29'($urandom), 2'b00};
               endcase
    endcase
    return a;
  endfunction

  // Monitor: pops the scoreboard whenever ready appears and checks timing, err, data and LEDs.
  bit         ledPending = 1'b0;
  logic [7:0] ledExp;
  int         ledId;
  always @(negedge clk) begin
    exp_t x;
    if (rst_n) begin
      if (ledPending) begin
        checkOutput($sformatf("txn%0d led_out", ledId), {24'h0, led_out}, {24'h0, ledExp});
        ledPending = 1'b0;
      end
      if (ready) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpected ready: got ready=1 at cycle %0d, expected no response", cyc);
        end else begin
          x = sbq.pop_front();
          checkOutput($sformatf("txn%0d ready cycle", x.id), 32'(cyc), 32'(x.expCycle));
          checkOutput($sformatf("txn%0d err", x.id), {31'h0, err}, {31'h0, x.e});
          if (x.checkData) checkOutput($sformatf("txn%0d rdata", x.id), rdata, x.rd);
          ledPending = 1'b1; ledExp = x.led; ledId = x.id;
        end
      end else begin
        checkOutput("idle rdata", rdata, 32'h0);
        checkOutput("idle err", {31'h0, err}, 32'h0);
        if (sbq.size() != 0 && cyc > sbq[0].expCycle) begin
          x = sbq.pop_front();
          total++; bad++;
          $display("[TB] FAIL txn%0d missing ready: got none by cycle %0d, expected at %0d", x.id, cyc, x.expCycle);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset ready", {31'h0, ready}, 32'h0);
    checkOutput("reset err", {31'h0, err}, 32'h0);
    checkOutput("reset rdata", rdata, 32'h0);
    checkOutput("reset led_out", {24'h0, led_out}, 32'h0);
    @(posedge clk); #1;
    $display("[TB] first request held across reset release");
    applyStimulus(1'b0, 32'h7F08, 32'h0, 0, 1'b1);

    $display("[TB] RAM write/read and fill");
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 1);
    applyStimulus(1'b0, 32'h10, 32'h0, 0);
    for (int i = 0; i < RAM_WORDS; i++)
      if (i != 4) applyStimulus(1'b1, 32'(i * 4), $urandom, 0);
    applyStimulus(1'b0, 32'h10, 32'h0, 1);
    applyStimulus(1'b0, 32'(4 * RAM_WORDS - 4), 32'h0, 0);

    $display("[TB] LED register");
    applyStimulus(1'b1, 32'h7F00, 32'h1A5, 0);
    applyStimulus(1'b0, 32'h7F00, 32'h0, 0);

    $display("[TB] misaligned and unmapped accesses");
    applyStimulus(1'b0, 32'h12, 32'h0, 0);
    applyStimulus(1'b0, 32'h9000, 32'h0, 0);
    applyStimulus(1'b1, 32'h12, 32'h11111111, 0);
    applyStimulus(1'b1, 32'(4 * RAM_WORDS), 32'h22222222, 0);
    applyStimulus(1'b0, 32'h10, 32'h0, 0);
    applyStimulus(1'b0, 32'h0, 32'h0, 0);

    $display("[TB] switches and cycle counter");
    setSwitches(8'h3C);
    applyStimulus(1'b0, 32'h7F04, 32'h0, 0);
    applyStimulus(1'b1, 32'h7F04, 32'hFF, 0);
    applyStimulus(1'b0, 32'h7F08, 32'h0, 2);
    applyStimulus(1'b1, 32'h7F08, 32'h0, 0);
    applyStimulus(1'b0, 32'h7F08, 32'h0, 3);
    applyStimulus(1'b0, 32'h7F08, 32'h0, 0);

    $display("[TB] reset during an LED write");
    req = 1'b1; we = 1'b1; addr = 32'h7F00; wdata = 32'h5A;
    @(posedge clk); #1;
    rst_n = 1'b0; req = 1'b0;
    @(negedge clk);
    checkOutput("midreset ready", {31'h0, ready}, 32'h0);
    checkOutput("midreset led_out", {24'h0, led_out}, 32'h0);
    checkOutput("midreset rdata", rdata, 32'h0);
    #1 rst_n = 1'b1;
    ledModel = '0; clearBase = 0;
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h7F00, 32'h0, 0);
    applyStimulus(1'b0, 32'h10, 32'h0, 0);
    applyStimulus(1'b0, 32'h7F08, 32'h0, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 19) == 0) setSwitches(8'($urandom));
      a = randomAddr();
      applyStimulus(1'($urandom), a, $urandom, $urandom_range(0, 2));
    end

    for (int i = 0; i < 50 && sbq.size() != 0; i++) @(posedge clk);
    if (sbq.size() != 0) begin
      total++; bad++;
      $display("[TB] FAIL drain: got %0d outstanding responses, expected 0", sbq.size());
    end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
